// File: rtl/freq_pkg.sv
// Shared types and helpers for the frequency/period measurement block.
//   state_t   : measurement FSM encoding (IDLE / ARM / MEAS)
//   CNT_W_DEF : default counter width
//   sat_inc   : increment that sticks at the all-ones value of a given width
package freq_pkg;

  localparam int unsigned CNT_W_DEF = 32;
  localparam int unsigned SAT_W     = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } state_t;

  // Saturating increment for counters up to SAT_W bits wide; w is the live width.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                               input int unsigned       w);
    logic [SAT_W-1:0] max_v;
    max_v = (w >= SAT_W) ? {SAT_W{1'b1}} : ((SAT_W'(1) << w) - SAT_W'(1));
    return (v >= max_v) ? max_v : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input followed by an edge detector.
//   Clk, Reset : clock, asynchronous active-high reset
//   din        : asynchronous input
//   rise_c     : one-cycle pulse on a synchronized 0->1 transition
//   fall_c     : one-cycle pulse on a synchronized 1->0 transition
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_d;
  logic                   level;

  assign level = sync_q[SYNC_STAGES-1];

  // Synchronizer chain plus one delayed copy of the synchronized level.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_q  <= '0;
      level_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      level_d <= level;
    end
  end

  assign rise_c = level & ~level_d;
  assign fall_c = ~level & level_d;

endmodule

// File: rtl/freq_measure.sv
// One-shot period / high-time measurement of an asynchronous input, in Clk cycles.
//   Clk, Reset    : clock, asynchronous active-high reset
//   SigIn         : signal under measurement (async)
//   Start         : one-cycle measurement request (ignored while Busy)
//   Din           : timeout limit value, loaded by ConfigTimeout in IDLE only
//   Busy          : measurement in progress
//   Valid         : one-cycle pulse, Period/HighTime updated
//   Timeout       : one-cycle pulse, measurement aborted (limit 0 disables)
//   Period        : Clk cycles between two consecutive rising edges
//   HighTime      : Clk cycles from the rising edge to the falling edge
module freq_measure
  import freq_pkg::*;
#(
  parameter int unsigned     CNT_W           = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_TIMEOUT = CNT_W'(32'hFFFF),
  parameter int unsigned     SYNC_STAGES     = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             SigIn,
  input  logic             Start,
  input  logic [CNT_W-1:0] Din,
  input  logic             ConfigTimeout,
  output logic             Busy,
  output logic             Valid,
  output logic             Timeout,
  output logic [CNT_W-1:0] Period,
  output logic [CNT_W-1:0] HighTime
);

  logic rise_c, fall_c;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .Clk    (Clk),
    .Reset  (Reset),
    .din    (SigIn),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  state_t           state_q, state_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx, wait_q, wait_nx;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_nx, limit_q, limit_nx;
  logic [CNT_W-1:0] period_nx, high_nx, cnt_inc, wait_inc;
  logic             hi_seen_q, hi_seen_nx, valid_nx, timeout_nx, timeout_hit;

  // State, counters and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wait_q    <= '0;
      hi_lat_q  <= '0;
      hi_seen_q <= 1'b0;
      limit_q   <= DEFAULT_TIMEOUT;
      Busy      <= 1'b0;
      Valid     <= 1'b0;
      Timeout   <= 1'b0;
      Period    <= '0;
      HighTime  <= '0;
    end else begin
      state_q   <= state_nx;
      cnt_q     <= cnt_nx;
      wait_q    <= wait_nx;
      hi_lat_q  <= hi_lat_nx;
      hi_seen_q <= hi_seen_nx;
      limit_q   <= limit_nx;
      Busy      <= (state_nx != ST_IDLE);
      Valid     <= valid_nx;
      Timeout   <= timeout_nx;
      Period    <= period_nx;
      HighTime  <= high_nx;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_nx   = state_q;
    cnt_nx     = cnt_q;
    wait_nx    = wait_q;
    hi_lat_nx  = hi_lat_q;
    hi_seen_nx = hi_seen_q;
    limit_nx   = limit_q;
    period_nx  = Period;
    high_nx    = HighTime;
    valid_nx   = 1'b0;
    timeout_nx = 1'b0;

    cnt_inc  = CNT_W'(sat_inc(SAT_W'(cnt_q), CNT_W));
    wait_inc = CNT_W'(sat_inc(SAT_W'(wait_q), CNT_W));
    // wait_q holds the number of busy cycles elapsed, counting the current one.
    timeout_hit = (limit_q != '0) && (wait_q >= limit_q);

    case (state_q)
      ST_IDLE: begin
        if (ConfigTimeout) limit_nx = Din;
        if (Start) begin
          state_nx = ST_ARM;
          wait_nx  = CNT_W'(1);
        end
      end
      ST_ARM: begin
        wait_nx = wait_inc;
        if (timeout_hit) begin
          state_nx   = ST_IDLE;
          timeout_nx = 1'b1;
        end else if (rise_c) begin
          state_nx   = ST_MEAS;
          cnt_nx     = CNT_W'(1);
          hi_seen_nx = 1'b0;
          hi_lat_nx  = '0;
        end
      end
      ST_MEAS: begin
        wait_nx = wait_inc;
        cnt_nx  = cnt_inc;
        if (fall_c && !hi_seen_q) begin
          hi_lat_nx  = cnt_q;
          hi_seen_nx = 1'b1;
        end
        // A completing rise takes priority over a simultaneous timeout.
        if (rise_c) begin
          state_nx  = ST_IDLE;
          period_nx = cnt_q;
          high_nx   = hi_seen_q ? hi_lat_q : '0;
          valid_nx  = 1'b1;
        end else if (timeout_hit) begin
          state_nx   = ST_IDLE;
          timeout_nx = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_freq_measure.sv
`timescale 1ns/1ps
module tb_freq_measure;

  logic        clk, rst, sig, start, cfg;
  logic [31:0] din;
  logic        busy, valid, timeout;
  logic [31:0] period, high_time;

  int checks   = 0;
  int failures = 0;

  // Generator control: 0 = off (bench holds sig), 1 = synchronous H/L, 2 = async 1 MHz
  int gen_mode = 0;
  int hi_len   = 5;
  int lo_len   = 5;

  int valid_total = 0;
  int to_total    = 0;

  freq_measure dut (
    .Clk           (clk),
    .Reset         (rst),
    .SigIn         (sig),
    .Start         (start),
    .Din           (din),
    .ConfigTimeout (cfg),
    .Busy          (busy),
    .Valid         (valid),
    .Timeout       (timeout),
    .Period        (period),
    .HighTime      (high_time)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always begin
    wait (gen_mode != 0);
    if (gen_mode == 1) begin
      sig = 1'b1;
      repeat (hi_len) @(negedge clk);
      sig = 1'b0;
      repeat (lo_len) @(negedge clk);
    end else begin
      sig = 1'b1;
      #500;
      sig = 1'b0;
      #500;
    end
  end

  always @(negedge clk) begin
    if (valid === 1'b1)   valid_total++;
    if (timeout === 1'b1) to_total++;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic stop_gen();
    gen_mode = 0;
    repeat (110) @(negedge clk);
    sig = 1'b0;
  endtask

  task automatic set_gen(input int h, input int l);
    stop_gen();
    hi_len = h;
    lo_len = l;
    gen_mode = 1;
    repeat (h + l + 5) @(negedge clk);
  endtask

  task automatic cfg_limit(input logic [31:0] v);
    @(negedge clk);
    cfg = 1'b1;
    din = v;
    @(negedge clk);
    cfg = 1'b0;
  endtask

  // Returns at the negedge following the clock edge that samples Start.
  task automatic pulse_start(input bit with_cfg, input logic [31:0] v);
    @(negedge clk);
    start = 1'b1;
    if (with_cfg) begin
      cfg = 1'b1;
      din = v;
    end
    @(negedge clk);
    start = 1'b0;
    cfg   = 1'b0;
  endtask

  // lat = clock edges after the Start-sampling edge until Valid or Timeout is seen.
  task automatic wait_done(input int k0, output int lat, output bit gv, output bit gt,
                           output bit busy_ok);
    logic prev_busy;
    lat = -1; gv = 1'b0; gt = 1'b0; busy_ok = 1'b0;
    for (int k = k0 + 1; k <= 3000; k++) begin
      prev_busy = busy;
      @(negedge clk);
      if (valid === 1'b1 || timeout === 1'b1) begin
        gv = valid;
        gt = timeout;
        lat = k;
        busy_ok = (busy === 1'b0) && (prev_busy === 1'b1);
        break;
      end
    end
  endtask

  initial begin
    int lat, h, l, exp_per, exp_hi, vt0, tt0, budget;
    bit gv, gt, bok;
    logic [31:0] p, ht;

    rst = 1'b1; start = 1'b0; cfg = 1'b0; din = '0; sig = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_period", period, 0);
    chk("rst_high", high_time, 0);
    rst = 1'b0;
    @(negedge clk);

    // Synchronous divide-by-10 source
    set_gen(5, 5);
    pulse_start(1'b0, '0);
    wait_done(0, lat, gv, gt, bok);
    chk("div10_valid", gv, 1);
    chk("div10_period", period, 10);
    chk("div10_high", high_time, 5);
    chk("div10_busy_edge", bok, 1);
    @(negedge clk);
    chk("div10_valid_pulse", valid, 0);
    exp_per = 10; exp_hi = 5;

    // Randomized synchronous sources: Period = H+L, HighTime = H
    for (int r = 0; r < 6; r++) begin
      h = int'($urandom_range(2, 30));
      l = int'($urandom_range(2, 30));
      set_gen(h, l);
      pulse_start(1'b0, '0);
      wait_done(0, lat, gv, gt, bok);
      chk("rand_valid", gv, 1);
      chk("rand_period", period, h + l);
      chk("rand_high", high_time, h);
      exp_per = h + l; exp_hi = h;
    end

    // Timeout with SigIn held low
    stop_gen();
    cfg_limit(32'd50);
    vt0 = valid_total;
    pulse_start(1'b0, '0);
    wait_done(0, lat, gv, gt, bok);
    chk("to50_flag", gt, 1);
    chk("to50_latency", lat, 50);
    chk("to50_period", period, exp_per);
    chk("to50_high", high_time, exp_hi);
    @(negedge clk);
    chk("to50_pulse", timeout, 0);
    chk("to50_no_valid", valid_total - vt0, 0);

    // ConfigTimeout while busy is ignored
    pulse_start(1'b0, '0);
    repeat (10) @(negedge clk);
    cfg = 1'b1; din = 32'd7;
    @(negedge clk);
    cfg = 1'b0;
    wait_done(11, lat, gv, gt, bok);
    chk("cfg_busy_latency", lat, 50);

    // ConfigTimeout in IDLE takes effect
    cfg_limit(32'd7);
    pulse_start(1'b0, '0);
    wait_done(0, lat, gv, gt, bok);
    chk("cfg_idle_latency", lat, 7);

    // Start and ConfigTimeout together: new limit applies to this measurement
    pulse_start(1'b1, 32'd12);
    wait_done(0, lat, gv, gt, bok);
    chk("cfg_same_latency", lat, 12);

    // Reset in the middle of a measurement
    cfg_limit(32'd0);
    set_gen(20, 20);
    pulse_start(1'b0, '0);
    budget = 0;
    while (sig !== 1'b0 && budget < 100) begin @(negedge clk); budget++; end
    while (sig !== 1'b1 && budget < 100) begin @(negedge clk); budget++; end
    chk("mid_rise_found", (budget < 100), 1);
    repeat (10) @(negedge clk);
    chk("mid_busy", busy, 1);
    vt0 = valid_total; tt0 = to_total;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_period", period, 0);
    chk("mid_rst_high", high_time, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid_no_valid", valid_total - vt0, 0);
    chk("mid_no_timeout", to_total - tt0, 0);
    chk("mid_idle", busy, 0);
    pulse_start(1'b0, '0);
    wait_done(0, lat, gv, gt, bok);
    chk("post_rst_valid", gv, 1);
    chk("post_rst_period", period, 40);
    chk("post_rst_high", high_time, 20);

    // SigIn already high at Start, 30% duty, period 40; extra Starts while busy
    set_gen(12, 28);
    budget = 0;
    while (sig !== 1'b0 && budget < 100) begin @(negedge clk); budget++; end
    while (sig !== 1'b1 && budget < 100) begin @(negedge clk); budget++; end
    repeat (4) @(negedge clk);
    vt0 = valid_total;
    pulse_start(1'b0, '0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(10, lat, gv, gt, bok);
    chk("hi_start_valid", gv, 1);
    chk("hi_start_period", period, 40);
    chk("hi_start_high", high_time, 12);
    repeat (60) @(negedge clk);
    chk("hi_start_one_valid", valid_total - vt0, 1);
    chk("hi_start_idle", busy, 0);

    // Asynchronous 1 MHz square wave, random phase per run
    for (int r = 0; r < 20; r++) begin
      stop_gen();
      #($urandom_range(0, 9999) / 1000.0);
      gen_mode = 2;
      repeat (110) @(negedge clk);
      pulse_start(1'b0, '0);
      wait_done(0, lat, gv, gt, bok);
      p = period; ht = high_time;
      chk("async_valid", gv, 1);
      chk("async_period", (p >= 99 && p <= 101), 1);
      chk("async_high", (ht >= 49 && ht <= 51), 1);
    end
    stop_gen();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
